// File: rtl/mux2entradas.sv
// Two-input WIDTH-bit selector. O is registered (1-cycle latency) or combinational, chosen by REGISTERED.
// sel codes 2/3 are illegal: O holds (or reads 0 when combinational) and sel_err is raised. en is the only flow control.
module mux2entradas #(
    parameter int WIDTH      = 32,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] O,
    output logic             sel_err
);

    logic sel_err_q;
    logic sel_err_d;

    always_comb begin
        sel_err_d = sel_err_q;
        if (en) begin
            sel_err_d = sel[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] o_q;
            logic [WIDTH-1:0] o_d;

            // Default arm holds, so an illegal or unknown sel never changes the stored value.
            always_comb begin
                o_d = o_q;
                if (en) begin
                    case (sel)
                        2'b00:   o_d = A;
                        2'b01:   o_d = B;
                        default: o_d = o_q;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    o_q <= '0;
                end else begin
                    o_q <= o_d;
                end
            end

            assign O = o_q;
        end else begin : g_comb
            logic [WIDTH-1:0] o_c;

            // A combinational path has nothing to hold, so illegal codes drive zero.
            always_comb begin
                o_c = '0;
                case (sel)
                    2'b00:   o_c = A;
                    2'b01:   o_c = B;
                    default: o_c = '0;
                endcase
            end

            assign O = o_c;
        end
    endgenerate

endmodule

// File: tb/tb_mux2entradas.sv
// Directed bench: table of vectors plus hand sequences, registered and combinational variants side by side.
module tb_mux2entradas;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic [31:0] o_r;
    logic        err_r;
    logic [31:0] o_c;
    logic        err_c;

    int n_cmp;
    int n_mis;

    mux2entradas #(.WIDTH(32), .REGISTERED(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .en(en), .A(a), .B(b), .sel(sel), .O(o_r), .sel_err(err_r)
    );

    mux2entradas #(.WIDTH(32), .REGISTERED(1'b0)) dut_comb (
        .clk(clk), .rst(rst), .en(en), .A(a), .B(b), .sel(sel), .O(o_c), .sel_err(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_o;
        logic        exp_err;
    } vec_t;

    vec_t vec [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] comb_model(input logic [1:0] s, input logic [31:0] xa, input logic [31:0] xb);
        if (s == 2'd0) return xa;
        if (s == 2'd1) return xb;
        return 32'd0;
    endfunction

    // Drive on the falling edge, check comb output before the rising edge, registered outputs 1 after it.
    task automatic step(input logic r, input logic e, input logic [1:0] s,
                        input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] exp_o, input logic exp_err, input string name);
        @(negedge clk);
        rst = r; en = e; sel = s; a = xa; b = xb;
        #1;
        chk({name, "_comb_o"}, o_c, comb_model(s, xa, xb));
        @(posedge clk);
        #1;
        chk({name, "_o"}, o_r, exp_o);
        chk({name, "_err"}, {31'd0, err_r}, {31'd0, exp_err});
        chk({name, "_comb_err"}, {31'd0, err_c}, {31'd0, exp_err});
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1; en = 1'b1; sel = 2'd0; a = 32'd3; b = 32'd5;

        //          rst   en    sel   A             B             O             err
        vec[0]  = '{1'b1, 1'b1, 2'd0, 32'd3,        32'd5,        32'd0,        1'b0};
        vec[1]  = '{1'b1, 1'b1, 2'd0, 32'd3,        32'd5,        32'd0,        1'b0};
        vec[2]  = '{1'b0, 1'b1, 2'd0, 32'd3,        32'd5,        32'd3,        1'b0};
        vec[3]  = '{1'b0, 1'b1, 2'd1, 32'd3,        32'd5,        32'd5,        1'b0};
        vec[4]  = '{1'b0, 1'b1, 2'd3, 32'd3,        32'd5,        32'd5,        1'b1};
        vec[5]  = '{1'b0, 1'b1, 2'd2, 32'd9,        32'd7,        32'd5,        1'b1};
        vec[6]  = '{1'b0, 1'b1, 2'd0, 32'd3,        32'd5,        32'd3,        1'b0};
        vec[7]  = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'd5,       32'd3,        1'b0};
        vec[8]  = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd5,       32'd3,        1'b0};
        vec[9]  = '{1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'd5,       32'd5,        1'b0};
        vec[10] = '{1'b0, 1'b1, 2'd2, 32'd1,        32'd2,        32'd5,        1'b1};
        vec[11] = '{1'b0, 1'b0, 2'd0, 32'd1,        32'd2,        32'd5,        1'b1};
        vec[12] = '{1'b1, 1'b0, 2'd3, 32'd1,        32'd2,        32'd0,        1'b0};
        vec[13] = '{1'b0, 1'b1, 2'd0, 32'h8000_0001, 32'd2,       32'h8000_0001, 1'b0};
        vec[14] = '{1'b1, 1'b1, 2'd1, 32'd1,        32'd2,        32'd0,        1'b0};
        vec[15] = '{1'b0, 1'b1, 2'd1, 32'd1,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};

        for (int i = 0; i < 16; i++) begin
            step(vec[i].rst, vec[i].en, vec[i].sel, vec[i].a, vec[i].b,
                 vec[i].exp_o, vec[i].exp_err, $sformatf("vec%0d", i));
        end

        // Select sweep, ten clocks per code, then recovery to sel 0.
        step(1'b1, 1'b1, 2'd0, 32'd3, 32'd5, 32'd0, 1'b0, "sweep_rst");
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 10; c++) begin
                step(1'b0, 1'b1, s[1:0], 32'd3, 32'd5, (s == 0) ? 32'd3 : 32'd5, (s >= 2),
                     $sformatf("sweep_s%0d_c%0d", s, c));
            end
        end
        step(1'b0, 1'b1, 2'd2, 32'd3, 32'd5, 32'd5, 1'b1, "recov_pre");
        step(1'b0, 1'b1, 2'd0, 32'd3, 32'd5, 32'd3, 1'b0, "recov");

        // Enable hold while sel and A move, then release.
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'd5, 32'd3, 1'b0, $sformatf("hold_c%0d", c));
        end
        step(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'd5, 32'd5, 1'b0, "hold_release");

        // Full-width alternation, one cycle behind sel.
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b1, {1'b0, c[0]}, 32'hA5A5_A5A5, 32'h5A5A_5A5A,
                 c[0] ? 32'h5A5A_5A5A : 32'hA5A5_A5A5, 1'b0, $sformatf("wide_c%0d", c));
        end

        // Combinational variant, explicit same-delta values.
        @(negedge clk);
        rst = 1'b0; en = 1'b1; a = 32'd3; b = 32'd5;
        sel = 2'd0; #1; chk("comb_sel0", o_c, 32'd3);
        sel = 2'd1; #1; chk("comb_sel1", o_c, 32'd5);
        sel = 2'd2; #1; chk("comb_sel2", o_c, 32'd0);
        chk("comb_err_before_edge", {31'd0, err_c}, 32'd0);
        @(posedge clk); #1;
        chk("comb_err_after_edge", {31'd0, err_c}, 32'd1);
        chk("reg_hold_sel2", o_r, 32'h5A5A_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
        $finish;
    end

endmodule
